// File: rtl/ysyx_25060166_exec_seq.sv
// Multi-cycle fetch/execute sequencer for the RV32E ADDI datapath.
// Optional retired-instruction counter (inst_cnt port) when YSYX_25060166_PERF_CNT_EN is defined.
module ysyx_25060166_exec_seq #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic [4:0]      rf_raddr1,
  input  logic [XLEN-1:0] rf_rdata1,
  output logic            rf_wen,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [XLEN-1:0] pc,
  output logic            halted,
  output logic            illegal
`ifdef YSYX_25060166_PERF_CNT_EN
  ,
  output logic [31:0]     inst_cnt
`endif
);

  // state | meaning
  // FETCH | request at pc, held stable until accepted
  // WAIT  | request accepted, waiting for instruction data
  // EXEC  | decode latched instruction, read rs1, compute result
  // WB    | one-cycle register write (suppressed for x0), pc += 4
  // HALT  | stopped on EBREAK or unsupported encoding; only rst exits
  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  state_t          state;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] imm;
  logic            is_addi;
  logic            is_ebreak;

  // x16-x31 do not exist in RV32E, so bit 4 of rs1/rd makes an ADDI illegal.
  assign is_ebreak = (inst == XLEN'(32'h0010_0073));
  assign is_addi   = (inst[6:0] == 7'b0010011) && (inst[14:12] == 3'b000) &&
                     !inst[19] && !inst[11];
  assign imm       = {{(XLEN-12){inst[31]}}, inst[31:20]};
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_FETCH;
      pc             <= RESET_PC;
      inst           <= '0;
      imem_req_valid <= 1'b1;
      rf_raddr1      <= 5'd0;
      rf_wen         <= 1'b0;
      rf_waddr       <= 5'd0;
      rf_wdata       <= '0;
      halted         <= 1'b0;
      illegal        <= 1'b0;
`ifdef YSYX_25060166_PERF_CNT_EN
      inst_cnt       <= 32'd0;
`endif
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_req_valid && imem_req_ready) begin
            imem_req_valid <= 1'b0;
            state          <= S_WAIT;
          end
        end
        S_WAIT: begin
          // rs1 address is registered here so the combinational read is ready in EXEC
          if (imem_resp_valid) begin
            inst      <= imem_resp_data;
            rf_raddr1 <= imem_resp_data[19:15];
            state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_addi) begin
            rf_waddr <= inst[11:7];
            rf_wdata <= rf_rdata1 + imm;
            rf_wen   <= (inst[11:7] != 5'd0);
            state    <= S_WB;
          end else begin
            halted  <= 1'b1;
            illegal <= !is_ebreak;
            state   <= S_HALT;
          end
        end
        S_WB: begin
          rf_wen         <= 1'b0;
          pc             <= pc + XLEN'(4);
          imem_req_valid <= 1'b1;
          state          <= S_FETCH;
`ifdef YSYX_25060166_PERF_CNT_EN
          inst_cnt       <= inst_cnt + 32'd1;
`endif
        end
        S_HALT: begin
          imem_req_valid <= 1'b0;
          rf_wen         <= 1'b0;
        end
        default: begin
          imem_req_valid <= 1'b0;
          rf_wen         <= 1'b0;
          halted         <= 1'b1;
          illegal        <= 1'b1;
          state          <= S_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25060166_exec_seq.sv
// Directed bench for ysyx_25060166_exec_seq: instruction-level model plus per-cycle monitor.
`timescale 1ns/1ps
module tb_ysyx_25060166_exec_seq;

  localparam logic [31:0] RPC    = 32'h8000_0000;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic [4:0]  rf_raddr1;
  logic [31:0] rf_rdata1;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pc;
  logic        halted;
  logic        illegal;
`ifdef YSYX_25060166_PERF_CNT_EN
  logic [31:0] inst_cnt;
  logic [31:0] w_cnt;
`endif

  logic        w_rst = 1'b1;
  logic        w_req_valid;
  logic        w_ready = 1'b1;
  logic [31:0] w_addr;
  logic        w_resp_valid = 1'b0;
  logic [31:0] w_resp_data = 32'h0050_0093;
  logic [4:0]  w_raddr;
  logic [31:0] w_rdata;
  logic        w_wen;
  logic [4:0]  w_waddr;
  logic [31:0] w_wdata;
  logic [31:0] w_pc;
  logic        w_halted;
  logic        w_illegal;

  always #5 clk = ~clk;

  ysyx_25060166_exec_seq dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .rf_raddr1(rf_raddr1), .rf_rdata1(rf_rdata1),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pc(pc), .halted(halted), .illegal(illegal)
`ifdef YSYX_25060166_PERF_CNT_EN
    , .inst_cnt(inst_cnt)
`endif
  );

  ysyx_25060166_exec_seq #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(w_rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_ready), .imem_addr(w_addr),
    .imem_resp_valid(w_resp_valid), .imem_resp_data(w_resp_data),
    .rf_raddr1(w_raddr), .rf_rdata1(w_rdata),
    .rf_wen(w_wen), .rf_waddr(w_waddr), .rf_wdata(w_wdata),
    .pc(w_pc), .halted(w_halted), .illegal(w_illegal)
`ifdef YSYX_25060166_PERF_CNT_EN
    , .inst_cnt(w_cnt)
`endif
  );

  assign w_rdata = '0;

  // Environment register array, with an override to present arbitrary rs1 values.
  logic [31:0] regs [16] = '{default: 32'd0};
  logic        ovr_en  = 1'b0;
  logic [31:0] ovr_val = '0;
  assign rf_rdata1 = ovr_en ? ovr_val :
                     ((rf_raddr1 == 5'd0 || rf_raddr1[4]) ? 32'd0 : regs[rf_raddr1[3:0]]);
  always @(posedge clk) if (rf_wen && rf_waddr != 5'd0) regs[rf_waddr[3:0]] <= rf_wdata;

  // Instruction-level model state.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
  } wr_t;
  wr_t         exp_q[$];
  logic [31:0] m_regs [16] = '{default: 32'd0};
  logic [31:0] m_pc = RPC;
  bit          m_halted = 1'b0;
  bit          m_illegal = 1'b0;

  int checks = 0;
  int failures = 0;

  function automatic void chk(input bit ok, input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Architectural effect of one fetched instruction.
  task automatic model(input logic [31:0] ins);
    int rs1, rd, imm, opnd;
    rs1 = int'(ins[19:15]);
    rd  = int'(ins[11:7]);
    imm = int'($signed(ins[31:20]));
    if (ins == EBREAK) begin
      m_halted  = 1'b1;
      m_illegal = 1'b0;
    end else if (ins[6:0] == 7'h13 && ins[14:12] == 3'd0 && rs1 < 16 && rd < 16) begin
      opnd = ovr_en ? int'(ovr_val) : ((rs1 == 0) ? 0 : int'(m_regs[rs1]));
      if (rd != 0) begin
        m_regs[rd] = 32'(opnd + imm);
        exp_q.push_back('{rd: 5'(rd), val: 32'(opnd + imm)});
      end
      m_pc = m_pc + 32'd4;
    end else begin
      m_halted  = 1'b1;
      m_illegal = 1'b1;
    end
  endtask

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_req_valid) begin
        chk(imem_addr === m_pc, "mon_addr", imem_addr, m_pc);
        chk(halted === 1'b0, "mon_fetch_while_halted", 32'(halted), 0);
      end
      if (imem_req_valid || halted) chk(pc === m_pc, "mon_pc", pc, m_pc);
      if (halted) begin
        chk(m_halted, "mon_unexpected_halt", 32'(halted), 32'(m_halted));
        chk(illegal === m_illegal, "mon_illegal", 32'(illegal), 32'(m_illegal));
      end
      if (rf_wen === 1'b1) begin
        chk(exp_q.size() > 0, "mon_unexpected_write", 32'(rf_waddr), 0);
        if (exp_q.size() > 0) begin
          chk(rf_waddr === exp_q[0].rd, "mon_waddr", 32'(rf_waddr), 32'(exp_q[0].rd));
          chk(rf_wdata === exp_q[0].val, "mon_wdata", rf_wdata, exp_q[0].val);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    step();
    step();
    m_pc      = RPC;
    m_halted  = 1'b0;
    m_illegal = 1'b0;
    exp_q.delete();
    rst = 1'b0;
  endtask

  // Drives one fetch with directed stalls; reports wdata and cycle of first observable effect.
  task automatic run_inst(input logic [31:0] ins, input int rdly, input int vdly,
                          input int exp_lat, output logic [31:0] wd);
    logic [31:0] a0;
    int lat, n;
    bit seen;
    lat = 1;
    chk(imem_req_valid === 1'b1, "fetch_valid", 32'(imem_req_valid), 1);
    a0 = imem_addr;
    for (int i = 0; i < rdly; i++) begin
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b1;
      imem_resp_data  = EBREAK;
      step();
      lat++;
      chk(imem_req_valid === 1'b1, "stall_valid", 32'(imem_req_valid), 1);
      chk(imem_addr === a0, "stall_addr", imem_addr, a0);
    end
    imem_resp_valid = 1'b0;
    imem_req_ready  = 1'b1;
    step();
    lat++;
    imem_req_ready = 1'b0;
    for (int i = 0; i < vdly; i++) begin
      step();
      lat++;
      chk(imem_req_valid === 1'b0, "wait_valid", 32'(imem_req_valid), 0);
    end
    model(ins);
    imem_resp_valid = 1'b1;
    imem_resp_data  = ins;
    step();
    lat++;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 12) begin
      if (rf_wen === 1'b1 || halted === 1'b1 || imem_req_valid === 1'b1) seen = 1'b1;
      else begin
        step();
        lat++;
        n++;
      end
    end
    chk(seen, "event_timeout", 32'(n), 12);
    chk(lat == exp_lat, "latency", 32'(lat), 32'(exp_lat));
    wd = rf_wdata;
    if (rf_wen === 1'b1) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] wd;
    do_reset();
    chk(imem_req_valid === 1'b1, "rst_req_valid", 32'(imem_req_valid), 1);
    chk(rf_wen === 1'b0, "rst_rf_wen", 32'(rf_wen), 0);
    chk(halted === 1'b0, "rst_halted", 32'(halted), 0);
    chk(illegal === 1'b0, "rst_illegal", 32'(illegal), 0);
    chk(pc === 32'h8000_0000, "rst_pc", pc, 32'h8000_0000);
    chk(imem_addr === 32'h8000_0000, "rst_addr", imem_addr, 32'h8000_0000);
`ifdef YSYX_25060166_PERF_CNT_EN
    chk(inst_cnt === 32'd0, "rst_inst_cnt", inst_cnt, 0);
`endif

    run_inst(32'h0050_0093, 0, 0, 4, wd);                 // addi x1,x0,5
    chk(wd === 32'd5, "addi5_wdata", wd, 5);
    chk(pc === 32'h8000_0004, "addi5_pc", pc, 32'h8000_0004);

    ovr_en = 1'b1;
    ovr_val = 32'd3;
    run_inst(32'hFFF0_8113, 0, 0, 4, wd);                 // addi x2,x1,-1
    chk(wd === 32'd2, "addi_m1_wdata", wd, 2);
    ovr_val = 32'd0;
    run_inst(32'hFFF0_8113, 0, 0, 4, wd);
    chk(wd === 32'hFFFF_FFFF, "addi_m1_zero_wdata", wd, 32'hFFFF_FFFF);
    ovr_en = 1'b0;

    run_inst(32'h00A0_8193, 3, 2, 9, wd);                 // addi x3,x1,10 with stalls
    chk(wd === 32'd15, "stall_wdata", wd, 15);

    run_inst(32'h0070_0013, 0, 0, 5, wd);                 // addi x0,x0,7
    chk(pc === 32'h8000_0014, "x0_pc", pc, 32'h8000_0014);

    run_inst(EBREAK, 0, 0, 4, wd);
    chk(halted === 1'b1, "ebreak_halted", 32'(halted), 1);
    chk(illegal === 1'b0, "ebreak_illegal", 32'(illegal), 0);
    chk(pc === 32'h8000_0014, "ebreak_pc", pc, 32'h8000_0014);
`ifdef YSYX_25060166_PERF_CNT_EN
    chk(inst_cnt === 32'd5, "inst_cnt_5", inst_cnt, 5);
`endif
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0050_0093;
    for (int i = 0; i < 3; i++) begin
      step();
      chk(halted === 1'b1 && imem_req_valid === 1'b0 && rf_wen === 1'b0, "halt_stays",
          {29'd0, halted, imem_req_valid, rf_wen}, 32'h4);
    end

    do_reset();
    chk(pc === 32'h8000_0000, "rerst_pc", pc, 32'h8000_0000);
    chk(imem_req_valid === 1'b1 && halted === 1'b0, "rerst_fetch",
        {30'd0, imem_req_valid, halted}, 32'h2);
`ifdef YSYX_25060166_PERF_CNT_EN
    chk(inst_cnt === 32'd0, "rerst_inst_cnt", inst_cnt, 0);
`endif

    run_inst(32'h0000_0033, 0, 0, 4, wd);
    chk(halted === 1'b1 && illegal === 1'b1, "op_illegal", {30'd0, halted, illegal}, 32'h3);
    do_reset();
    run_inst(32'h0010_0813, 0, 0, 4, wd);                 // addi x16,x0,1
    chk(illegal === 1'b1, "rd16_illegal", 32'(illegal), 1);
    do_reset();
    run_inst(32'h0018_0093, 0, 0, 4, wd);                 // addi x1,x16,1
    chk(illegal === 1'b1, "rs16_illegal", 32'(illegal), 1);

    do_reset();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    chk(imem_req_valid === 1'b0, "midfetch_wait", 32'(imem_req_valid), 0);
    do_reset();
    chk(imem_req_valid === 1'b1 && pc === 32'h8000_0000, "midfetch_rst_pc", pc, 32'h8000_0000);
    run_inst(32'h0050_0093, 0, 0, 4, wd);
    chk(wd === 32'd5, "midfetch_resume_wdata", wd, 5);

    w_rst = 1'b1;
    step();
    w_rst = 1'b0;
    chk(w_addr === 32'hFFFF_FFFC && w_req_valid === 1'b1, "wrap_rst_addr", w_addr, 32'hFFFF_FFFC);
    step();
    w_resp_valid = 1'b1;
    step();
    w_resp_valid = 1'b0;
    step();
    chk(w_wen === 1'b1 && w_waddr === 5'd1 && w_wdata === 32'd5, "wrap_write", w_wdata, 5);
    chk(w_raddr === 5'd0 && w_halted === 1'b0 && w_illegal === 1'b0, "wrap_status",
        {25'd0, w_raddr, w_halted, w_illegal}, 0);
    step();
    chk(w_pc === 32'd0, "wrap_pc", w_pc, 0);
    chk(w_addr === 32'd0 && w_req_valid === 1'b1, "wrap_next_addr", w_addr, 0);
`ifdef YSYX_25060166_PERF_CNT_EN
    chk(w_cnt === 32'd1, "wrap_inst_cnt", w_cnt, 1);
`endif

    step();
    chk(exp_q.size() == 0, "pending_writes", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_25060166_exec_seq.md
Name: ysyx_25060166_exec_seq

Overview:
- Multi-cycle fetch/execute sequencer for the RV32E core's ADDI datapath. Replaces free-running "pc+4 every cycle" fetch.
- Owns the PC and fetches one instruction over a valid/ready request and valid response interface. Latches it and decodes it.
- Drives the register-array read/write ports for I-type ADDI, one instruction at a time. Stops on EBREAK or any unsupported encoding.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset
- XLEN, 32, data/address width (matches `ysyx_25060166_WIDTH)

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  XLEN  fetch address (= pc while req_valid)
- imem_resp_valid  in  1  instruction data valid
- imem_resp_data  in  XLEN  fetched instruction
- rf_raddr1  out  5  register-array read address 1
- rf_rdata1  in  XLEN  register-array read data 1 (combinational read)
- rf_wen  out  1  register-array write enable
- rf_waddr  out  5  write destination rd
- rf_wdata  out  XLEN  write data
- pc  out  XLEN  current PC
- halted  out  1  sequencer stopped
- illegal  out  1  stop cause was an unsupported instruction

Behaviour:
- Reset (rst=1 at posedge)
  - state=FETCH, pc=RESET_PC, inst register=0.
  - Outputs after reset: imem_req_valid=1 (FETCH), rf_wen=0, halted=0, illegal=0.
  - rst overrides every state, including HALT and mid-fetch. The memory shares rst, so no stale response survives reset.
- FETCH
  - imem_req_valid=1, imem_addr=pc.
  - Request is accepted on a cycle with valid&ready; the next state is WAIT.
  - Without ready, valid and addr stay stable; no drop, no address change.
- WAIT
  - imem_req_valid=0.
  - On imem_resp_valid, latch imem_resp_data into inst and go to EXEC. Otherwise stay.
  - imem_resp_valid in any other state is ignored.
- EXEC
  - Decode inst.
    - ADDI: opcode 7'b0010011 with funct3 3'b000.
    - EBREAK: inst == 32'h0010_0073.
  - ADDI: rf_raddr1=inst[19:15]; register sign-extended imm = {{20{inst[31]}}, inst[31:20]} and rf_rdata1; go to WB.
  - EBREAK: go to HALT, illegal=0.
  - Anything else: go to HALT, illegal=1. This includes rs1/rd with bit 4 set (x16–x31 are illegal in RV32E).
- WB (exactly one cycle)
  - rf_waddr=inst[11:7], rf_wdata=rf_rdata1+imm, modulo 2^32 with carry discarded.
  - rf_wen=1 only when rd != 0. With rd=x0, rf_wen=0 and the state still advances.
  - pc <= pc+4 (wraps 32'hFFFF_FFFC -> 0); next state FETCH.
- HALT
  - halted=1, all request/write outputs 0, pc frozen at the halting instruction.
  - Leave only via rst.
- rf_wen is 0 in every state except WB. rf_raddr1/rf_waddr/rf_wdata are don't-care when unused but must hold the last decoded values (no X).
- Minimum latency per ADDI: 4 cycles (FETCH accepted, response on the next cycle, EXEC, WB).
- Each wait cycle on imem_req_ready or imem_resp_valid adds one cycle.

Optional Feature:
- Macro: YSYX_25060166_PERF_CNT_EN
- Defined:
  - Adds output port inst_cnt (out, 32), reset to 0.
  - Increments by 1 on each WB cycle; rd=x0 counts. Wraps at 2^32.
  - Not incremented for halting instructions.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then addi x1,x0,5 (32'h0050_0093), ready/resp immediate -> imem_addr=0x8000_0000; rf_wen=1, rf_waddr=1, rf_wdata=5 at cycle 4; pc=0x8000_0004.
- rf_rdata1=32'h0000_0003 with addi x2,x1,-1 (32'hFFF0_8113) -> rf_wdata=2. With rf_rdata1=0 -> rf_wdata=32'hFFFF_FFFF.
- imem_req_ready held low 3 cycles, imem_resp_valid delayed 2 cycles -> req_valid/addr stable throughout; WB at cycle 9; one write only.
- addi x0,x0,7 (32'h0070_0013) -> rf_wen stays 0, pc advances by 4. Then EBREAK -> halted=1, illegal=0, pc unchanged.
- Instruction 32'h0000_0033 -> halted=1, illegal=1. rst pulse while halted -> pc=0x8000_0000, FETCH resumes; inst_cnt=0 when PERF_CNT_EN is defined.
- Reset with RESET_PC=32'hFFFF_FFFC, one ADDI -> pc wraps to 0; next imem_addr=0.
